bp_chooser_table_ctrl: RTL and testbench

// Controller that owns the single-ported tournament chooser table (one 2-bit counter per

---
 rtl/bp_chooser_table_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_bp_chooser_table_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_chooser_table_ctrl.sv
// Tournament chooser table controller.
// Arbitrates the single SRAM port between fetch lookups and buffered
// read-modify-write updates from resolved branches, and sweeps the table to
// CTR_INIT after reset.
// Optional feature macro: BP_PERF_CNT_EN adds perf_upd_cnt / perf_drop_cnt.
//
// state   | meaning
// INIT    | reset sweep, one CTR_INIT write per cycle
// IDLE    | serve a lookup, or start an update by reading its counter
// UPD_WR  | write the adjusted counter back (second half of the RMW)
module bp_chooser_table_ctrl #(
  parameter int         IDX_W      = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] CTR_INIT   = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             lookup_req,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_gnt,
  output logic             lookup_valid,
  output logic             lookup_sel,
  input  logic [6:0]       ex_mem_opcode,
  input  logic [IDX_W-1:0] ex_mem_idx,
  input  logic             ex_mem_lc_dir,
  input  logic             ex_mem_gl_dir,
  input  logic             ex_mem_br_en,
  output logic             upd_full,
  output logic             init_done,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
`ifdef BP_PERF_CNT_EN
  output logic [31:0]      perf_upd_cnt,
  output logic [31:0]      perf_drop_cnt,
`endif
  input  logic [1:0]       tbl_rdata
);

  localparam int         PTR_W     = $clog2(FIFO_DEPTH);
  localparam int         CNT_W     = PTR_W + 1;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_UPD_WR} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   sweep_ptr;
  logic [IDX_W-1:0]   fifo_idx [FIFO_DEPTH];
  logic               fifo_lc  [FIFO_DEPTH];
  logic               fifo_br  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   rmw_idx;
  logic               rmw_lc, rmw_br;
  logic [1:0]         rmw_wdata;
  logic               full, enq, deq, enq_ok;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign upd_full = rst & full;
  // Equal local/global directions carry no information for the chooser.
  assign enq      = (ex_mem_opcode == OP_BRANCH) && !stall && init_done &&
                    (ex_mem_lc_dir != ex_mem_gl_dir);
  // When full, an enqueue survives only if the head leaves in the same cycle.
  assign enq_ok   = enq && (!full || deq);
  assign lookup_sel = lookup_valid & tbl_rdata[1];

  // Saturating counter step: move toward local when local was right.
  always_comb begin
    rmw_wdata = tbl_rdata;
    if (rmw_lc == rmw_br) begin
      if (tbl_rdata != 2'b00) rmw_wdata = tbl_rdata - 2'b01;
    end else begin
      if (tbl_rdata != 2'b11) rmw_wdata = tbl_rdata + 2'b01;
    end
  end

  // Next state and SRAM port drive; everything forced idle while in reset.
  always_comb begin
    state_nxt  = state;
    lookup_gnt = 1'b0;
    tbl_en     = 1'b0;
    tbl_we     = 1'b0;
    tbl_addr   = '0;
    tbl_wdata  = 2'b00;
    deq        = 1'b0;
    if (rst) begin
      case (state)
        ST_INIT: begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = sweep_ptr;
          tbl_wdata = CTR_INIT;
          if (sweep_ptr == '1) state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (lookup_req && !full) begin
            lookup_gnt = 1'b1;
            tbl_en     = 1'b1;
            tbl_addr   = lookup_idx;
          end else if (count != '0) begin
            tbl_en    = 1'b1;
            tbl_addr  = fifo_idx[rd_ptr];
            deq       = 1'b1;
            state_nxt = ST_UPD_WR;
          end
        end
        ST_UPD_WR: begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = rmw_idx;
          tbl_wdata = rmw_wdata;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  // FSM state, sweep pointer, init flag and lookup response timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_INIT;
      sweep_ptr    <= '0;
      init_done    <= 1'b0;
      lookup_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      lookup_valid <= lookup_gnt;
      if (state == ST_INIT) begin
        sweep_ptr <= sweep_ptr + IDX_W'(1);
        if (sweep_ptr == '1) init_done <= 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy and the RMW holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rmw_idx <= '0;
      rmw_lc  <= 1'b0;
      rmw_br  <= 1'b0;
    end else begin
      if (enq_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rmw_idx <= fifo_idx[rd_ptr];
        rmw_lc  <= fifo_lc[rd_ptr];
        rmw_br  <= fifo_br[rd_ptr];
      end
      if (enq_ok && !deq)      count <= count + CNT_W'(1);
      else if (!enq_ok && deq) count <= count - CNT_W'(1);
    end
  end

  // FIFO storage; contents are meaningless outside the valid window.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      fifo_idx[wr_ptr] <= ex_mem_idx;
      fifo_lc[wr_ptr]  <= ex_mem_lc_dir;
      fifo_br[wr_ptr]  <= ex_mem_br_en;
    end
  end

`ifdef BP_PERF_CNT_EN
  // Completed write-backs and dropped enqueues, free-running and wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_upd_cnt  <= '0;
      perf_drop_cnt <= '0;
    end else begin
      if (state == ST_UPD_WR)   perf_upd_cnt  <= perf_upd_cnt + 32'd1;
      if (enq && !enq_ok)       perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_chooser_table_ctrl.sv
// Bench for bp_chooser_table_ctrl (IDX_W=4, FIFO_DEPTH=4) with an SRAM model
// and scoreboards for write-backs and lookup responses.
module tb_bp_chooser_table_ctrl;
  localparam int         IDX_W = 4;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic             clk, rst, stall, lookup_req;
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_gnt, lookup_valid, lookup_sel;
  logic [6:0]       ex_mem_opcode;
  logic [IDX_W-1:0] ex_mem_idx;
  logic             ex_mem_lc_dir, ex_mem_gl_dir, ex_mem_br_en;
  logic             upd_full, init_done, tbl_en, tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata, tbl_rdata;
`ifdef BP_PERF_CNT_EN
  logic [31:0]      perf_upd_cnt, perf_drop_cnt;
`endif

  bp_chooser_table_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(4), .CTR_INIT(2'b01)) dut (
    .clk(clk), .rst(rst), .stall(stall), .lookup_req(lookup_req), .lookup_idx(lookup_idx),
    .lookup_gnt(lookup_gnt), .lookup_valid(lookup_valid), .lookup_sel(lookup_sel),
    .ex_mem_opcode(ex_mem_opcode), .ex_mem_idx(ex_mem_idx), .ex_mem_lc_dir(ex_mem_lc_dir),
    .ex_mem_gl_dir(ex_mem_gl_dir), .ex_mem_br_en(ex_mem_br_en), .upd_full(upd_full),
    .init_done(init_done), .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata),
`ifdef BP_PERF_CNT_EN
    .perf_upd_cnt(perf_upd_cnt), .perf_drop_cnt(perf_drop_cnt),
`endif
    .tbl_rdata(tbl_rdata));

  typedef struct packed {logic [IDX_W-1:0] addr; logic [1:0] data;} wr_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] mem     [16];
  logic [1:0] ref_tbl [16];
  wr_t        exp_wr[$];
  logic       exp_lk[$];
  logic [1:0] wr_log[$];
  bit         upd_mon = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM: read data registered, held across writes.
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
  end

  // Write-back scoreboard.
  always @(negedge clk) begin
    if (upd_mon && rst && tbl_en && tbl_we) begin
      wr_t e;
      wr_log.push_back(tbl_wdata);
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL upd_write: got addr=%0d data=%b, expected no write", tbl_addr, tbl_wdata);
      end else begin
        e = exp_wr.pop_front();
        if (tbl_addr !== e.addr || tbl_wdata !== e.data) begin
          n_fail++;
          $display("FAIL upd_write: got addr=%0d data=%b, expected addr=%0d data=%b",
                   tbl_addr, tbl_wdata, e.addr, e.data);
        end
      end
    end
  end

  // Lookup scoreboard: expectation taken from table contents at grant.
  always @(negedge clk) begin
    if (lookup_valid === 1'b1) begin
      logic e;
      n_checks++;
      if (exp_lk.size() == 0) begin
        n_fail++;
        $display("FAIL lookup_valid: got unexpected valid, expected none");
      end else begin
        e = exp_lk.pop_front();
        if (lookup_sel !== e) begin
          n_fail++;
          $display("FAIL lookup_sel: got %b, expected %b", lookup_sel, e);
        end
      end
    end
    if (lookup_gnt === 1'b1) exp_lk.push_back(mem[lookup_idx][1]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [IDX_W-1:0] idx, input logic lc, input logic gl,
                         input logic br, input logic stl, input bit expect_wr);
    ex_mem_opcode = OP_BR;
    ex_mem_idx    = idx;
    ex_mem_lc_dir = lc;
    ex_mem_gl_dir = gl;
    ex_mem_br_en  = br;
    stall         = stl;
    if (expect_wr) begin
      logic [1:0] v;
      v = ref_tbl[idx];
      if (lc == br) v = (v == 2'b00) ? 2'b00 : v - 2'b01;
      else          v = (v == 2'b11) ? 2'b11 : v + 2'b01;
      ref_tbl[idx] = v;
      exp_wr.push_back({idx, v});
    end
  endtask

  task automatic clr_upd();
    ex_mem_opcode = 7'd0;
    stall         = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((exp_wr.size() != 0 || exp_lk.size() != 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    n_checks++;
    if (exp_wr.size() != 0 || exp_lk.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending writes=%0d lookups=%0d, expected 0 within %0d cycles",
               exp_wr.size(), exp_lk.size(), budget);
    end
    step();
  endtask

  // Called right after rst release; lookup_req is held high throughout.
  task automatic sweep_check();
    for (int i = 0; i < 16; i++) ref_tbl[i] = 2'b01;
    lookup_req = 1'b1;
    lookup_idx = 4'd2;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (tbl_en !== 1'b1 || tbl_we !== 1'b1 || tbl_addr !== 4'(i) || tbl_wdata !== 2'b01) begin
        n_fail++;
        $display("FAIL sweep_write[%0d]: got en=%b we=%b addr=%0d data=%b, expected 1 1 %0d 01",
                 i, tbl_en, tbl_we, tbl_addr, tbl_wdata, i);
      end
      n_checks++;
      if (lookup_gnt !== 1'b0 || init_done !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_gnt[%0d]: got gnt=%b init_done=%b, expected 0 0", i, lookup_gnt, init_done);
      end
    end
    step();
    lookup_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL init_done: got %b, expected 1", init_done);
    end
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if ({tbl_en, tbl_we, lookup_gnt, upd_full, init_done, lookup_valid} !== 6'b0 ||
        tbl_addr !== 4'd0 || tbl_wdata !== 2'b00) begin
      n_fail++;
      $display("FAIL %s: got en=%b we=%b gnt=%b full=%b done=%b valid=%b addr=%0d wdata=%b, expected all 0",
               tag, tbl_en, tbl_we, lookup_gnt, upd_full, init_done, lookup_valid, tbl_addr, tbl_wdata);
    end
`ifdef BP_PERF_CNT_EN
    n_checks++;
    if (perf_upd_cnt !== 32'd0 || perf_drop_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL %s_perf: got upd=%0d drop=%0d, expected 0 0", tag, perf_upd_cnt, perf_drop_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    lookup_req = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    step();
    rst = 1'b1;
    sweep_check();
    upd_mon = 1;
  endtask

  task automatic test_rmw_lookup();
    set_upd(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    clr_upd();
    @(negedge clk);
    n_checks++;
    if (tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_addr !== 4'd3) begin
      n_fail++;
      $display("FAIL rmw_read: got en=%b we=%b addr=%0d, expected 1 0 3", tbl_en, tbl_we, tbl_addr);
    end
    @(negedge clk);
    n_checks++;
    if (tbl_we !== 1'b1 || tbl_addr !== 4'd3 || tbl_wdata !== 2'b10) begin
      n_fail++;
      $display("FAIL rmw_write: got we=%b addr=%0d data=%b, expected 1 3 10", tbl_we, tbl_addr, tbl_wdata);
    end
    step();
    lookup_idx = 4'd3;
    lookup_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (lookup_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL lookup_gnt: got %b, expected 1", lookup_gnt);
    end
    step();
    lookup_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (lookup_valid !== 1'b1 || lookup_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL lookup_resp: got valid=%b sel=%b, expected 1 1", lookup_valid, lookup_sel);
    end
    step();
    wait_drain(20);
  endtask

  task automatic test_no_enqueue();
    set_upd(4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_upd(4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    clr_upd();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (tbl_en !== 1'b0 || upd_full !== 1'b0) begin
        n_fail++;
        $display("FAIL no_enqueue[%0d]: got en=%b full=%b, expected 0 0", i, tbl_en, upd_full);
      end
    end
    step();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_seq [7];
    exp_seq = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    wr_log.delete();
    for (int i = 0; i < 3; i++) begin
      set_upd(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
    end
    clr_upd();
    wait_drain(30);
    for (int i = 0; i < 4; i++) begin
      set_upd(4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
    end
    clr_upd();
    wait_drain(30);
    n_checks++;
    if (wr_log.size() != 7) begin
      n_fail++;
      $display("FAIL sat_count: got %0d writes, expected 7", wr_log.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (wr_log[i] !== exp_seq[i]) begin
          n_fail++;
          $display("FAIL sat_seq[%0d]: got %b, expected %b", i, wr_log[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_full_drop();
    int  c = 0;
    bit  saw = 0;
    lookup_idx = 4'd7;
    lookup_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_upd(4'(i), 1'b1, 1'b0, (i % 2) == 1, 1'b0, i < 5);
      @(negedge clk);
      if (i == 4) begin
        n_checks++;
        if (upd_full !== 1'b1 || lookup_gnt !== 1'b0 || tbl_en !== 1'b1 || tbl_we !== 1'b0) begin
          n_fail++;
          $display("FAIL full_priority: got full=%b gnt=%b en=%b we=%b, expected 1 0 1 0",
                   upd_full, lookup_gnt, tbl_en, tbl_we);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (upd_full !== 1'b1 || tbl_we !== 1'b1) begin
          n_fail++;
          $display("FAIL full_drop_cycle: got full=%b we=%b, expected 1 1", upd_full, tbl_we);
        end
      end
      step();
    end
    clr_upd();
    while (!saw && c < 20) begin
      @(negedge clk);
      if (lookup_gnt === 1'b1) saw = 1;
      c++;
    end
    n_checks++;
    if (!saw) begin
      n_fail++;
      $display("FAIL lookup_resume: got no grant in 20 cycles, expected a grant");
    end
    step();
    lookup_req = 1'b0;
    wait_drain(40);
`ifdef BP_PERF_CNT_EN
    n_checks++;
    if (perf_drop_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_drop: got %0d, expected 1", perf_drop_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_rmw();
    upd_mon = 0;
    lookup_idx = 4'd1;
    lookup_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_upd(4'(8 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    clr_upd();
    lookup_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (tbl_we !== 1'b1 || tbl_addr !== 4'd8) begin
      n_fail++;
      $display("FAIL pre_rst_upd_wr: got we=%b addr=%0d, expected 1 8", tbl_we, tbl_addr);
    end
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rmw_reset");
    exp_wr.delete();
    step();
    rst = 1'b1;
    sweep_check();
    upd_mon = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (tbl_en !== 1'b0 || upd_full !== 1'b0) begin
        n_fail++;
        $display("FAIL fifo_cleared[%0d]: got en=%b full=%b, expected 0 0", i, tbl_en, upd_full);
      end
    end
`ifdef BP_PERF_CNT_EN
    n_checks++;
    if (perf_upd_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_upd_after_rst: got %0d, expected 0", perf_upd_cnt);
    end
`endif
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'b11;
    tbl_rdata     = 2'b00;
    rst           = 1'b0;
    stall         = 1'b0;
    lookup_req    = 1'b0;
    lookup_idx    = '0;
    ex_mem_opcode = 7'd0;
    ex_mem_idx    = '0;
    ex_mem_lc_dir = 1'b0;
    ex_mem_gl_dir = 1'b0;
    ex_mem_br_en  = 1'b0;
    test_reset();
    test_rmw_lookup();
    test_no_enqueue();
    test_saturation();
    test_full_drop();
    test_reset_mid_rmw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
